// File: rtl/id_ex_ctrl_stage_pkg.sv
// Shared opcode/aluop encodings and control-bundle layout for the ID stage
// and the EX-stage ALU control decoder.
package id_ex_ctrl_stage_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [3:0] {
    ALUOP_RTYPE = 4'b0000,
    ALUOP_J     = 4'b0010,
    ALUOP_LW    = 4'b0011,
    ALUOP_BEQ   = 4'b0100,
    ALUOP_SW    = 4'b1011
  } aluop_e;

  // Bit positions of the packed control bundle below (MSB first).
  localparam int unsigned CTRL_REGWRITE  = 11;
  localparam int unsigned CTRL_MEMTOREG  = 10;
  localparam int unsigned CTRL_MEMWRITE  = 9;
  localparam int unsigned CTRL_MEMREAD   = 8;
  localparam int unsigned CTRL_BRANCH    = 7;
  localparam int unsigned CTRL_JUMP      = 6;
  localparam int unsigned CTRL_ALUSRC    = 5;
  localparam int unsigned CTRL_REGDST    = 4;
  localparam int unsigned CTRL_ALUOP_LSB = 0;
  localparam int unsigned CTRL_W         = 12;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic       regdst;
    logic [3:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/id_ex_ctrl_stage_main_decoder.sv
// Combinational opcode decoder: control bundle plus unknown-opcode flag.
module main_decoder
  import id_ex_ctrl_stage_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.aluop    = ALUOP_RTYPE;
      end
      OP_LW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memread  = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.aluop    = ALUOP_LW;
      end
      OP_SW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memwrite = 1'b1;
        o_ctrl.aluop    = ALUOP_SW;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.aluop  = ALUOP_BEQ;
      end
      OP_J: begin
        o_ctrl.jump  = 1'b1;
        o_ctrl.aluop = ALUOP_J;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID stage: decode, load-use stall, flush bubbles and the ID/EX register.
module id_ex_ctrl_stage
  import id_ex_ctrl_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ifid_inst,
  input  logic              ifid_valid,
  input  logic              flush,
  output logic              ex_memread,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic [3:0]        ex_aluop,
  output logic [5:0]        ex_func,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              ex_illegal,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              id_jump
);

  logic [5:0]        w_opcode;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  ctrl_t             w_ctrl;
  logic              w_illegal;
  logic              w_reads_rt;
  logic              w_hazard;
  logic              w_bubble;
  logic              w_unused_shamt;

  ctrl_t             r_ctrl;
  logic [5:0]        r_func;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic              r_valid;
  logic              r_illegal;

  assign w_opcode       = ifid_inst[31:26];
  assign w_rs           = ifid_inst[21 +: REG_AW];
  assign w_rt           = ifid_inst[16 +: REG_AW];
  assign w_rd           = ifid_inst[11 +: REG_AW];
  assign w_unused_shamt = ^ifid_inst[10:6];

  main_decoder u_main_decoder (
    .i_opcode  (w_opcode),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  // lw and j carry no source operand in the rt field.
  assign w_reads_rt = !(w_opcode == OP_LW || w_opcode == OP_J);

  assign w_hazard = r_valid & r_ctrl.memread & ifid_valid & (r_rt != '0) &
                    ((r_rt == w_rs) | (w_reads_rt & (r_rt == w_rt)));

  // Flush wins: the stalled instruction is being squashed, so fetch keeps moving.
  assign pc_write   = ~(w_hazard & ~flush);
  assign ifid_write = ~(w_hazard & ~flush);
  assign id_jump    = ifid_valid & w_ctrl.jump & ~flush;
  assign w_bubble   = flush | w_hazard | ~ifid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_func    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_bubble) begin
      r_ctrl    <= '0;
      r_func    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl;
      r_func    <= ifid_inst[5:0];
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_rd      <= w_rd;
      r_valid   <= 1'b1;
      r_illegal <= w_illegal;
    end
  end

  assign ex_regwrite = r_ctrl.regwrite;
  assign ex_memtoreg = r_ctrl.memtoreg;
  assign ex_memwrite = r_ctrl.memwrite;
  assign ex_memread  = r_ctrl.memread;
  assign ex_branch   = r_ctrl.branch;
  assign ex_jump     = r_ctrl.jump;
  assign ex_alusrc   = r_ctrl.alusrc;
  assign ex_regdst   = r_ctrl.regdst;
  assign ex_aluop    = r_ctrl.aluop;
  assign ex_func     = r_func;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign ex_valid    = r_valid;
  assign ex_illegal  = r_illegal;

endmodule
